// File: rtl/fft_pkg.sv
// fft_pkg: constants shared by the FFT stages and the saturating N+1 -> N narrowing helper.
package fft_pkg;
    localparam int DEF_DATA_FFT_SIZE = 16;
    localparam TYPE_FORVARD = "forvard";
    localparam TYPE_INVERSE = "inverse";
    localparam SCALE_HALF   = "half";
    localparam SCALE_NONE   = "none";

    // An N+1 bit sum overflows N bits exactly when its top two bits differ.
    function automatic logic signed [DEF_DATA_FFT_SIZE-1:0] sat_add(
        input logic signed [DEF_DATA_FFT_SIZE:0] s
    );
        return (s[DEF_DATA_FFT_SIZE] != s[DEF_DATA_FFT_SIZE-1])
            ? {s[DEF_DATA_FFT_SIZE], {(DEF_DATA_FFT_SIZE-1){~s[DEF_DATA_FFT_SIZE]}}}
            : s[DEF_DATA_FFT_SIZE-1:0];
    endfunction
endpackage

// File: rtl/fft_align_fifo.sv
// fft_align_fifo: synchronous FIFO that holds x0 while its partner passes through the twiddle multiplier.
module fft_align_fifo #(
    parameter int W = 32,
    parameter int L = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic [L:0]   o_level,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [2**L];
    logic [L:0]   r_wr;
    logic [L:0]   r_rd;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr[L-1:0]] <= i_data;
    end

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[L] != r_rd[L]) && (r_wr[L-1:0] == r_rd[L-1:0]);
    assign o_level = r_wr - r_rd;
    assign o_data  = r_mem[r_rd[L-1:0]];
endmodule

// File: rtl/fft_butterfly_combine.sv
// fft_butterfly_combine: radix-2 butterfly back end forming A = x0 + W*x1 and B = x0 - W*x1.
module fft_butterfly_combine
    import fft_pkg::*;
#(
    parameter int DATA_FFT_SIZE   = DEF_DATA_FFT_SIZE,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter     TYPE            = TYPE_FORVARD,
    parameter     SCALE           = SCALE_HALF
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_en,
    input  logic                              i_x0_valid,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_x0_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_x0_q,
    input  logic                              i_tw_valid,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_tw_minus_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_tw_minus_q,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_tw_plus_i,
    input  logic signed [DATA_FFT_SIZE-1:0]   i_tw_plus_q,
    output logic                              o_out_valid,
    output logic signed [DATA_FFT_SIZE-1:0]   o_out_a_i,
    output logic signed [DATA_FFT_SIZE-1:0]   o_out_a_q,
    output logic signed [DATA_FFT_SIZE-1:0]   o_out_b_i,
    output logic signed [DATA_FFT_SIZE-1:0]   o_out_b_q,
    output logic [FIFO_DEPTH_LOG2:0]          o_fifo_level,
    output logic                              o_err_overflow,
    output logic                              o_err_underflow
);
    localparam int N    = DATA_FFT_SIZE;
    localparam bit INV  = (TYPE == TYPE_INVERSE);
    localparam bit HALF = (SCALE == SCALE_HALF);

    logic                 w_pop, w_push, w_drop, w_full, w_empty;
    logic [2*N-1:0]       w_rd;
    logic signed [N-1:0]  w_x0_i, w_x0_q, w_w_i, w_w_q;
    logic signed [N:0]    w_sa_i, w_sa_q, w_sb_i, w_sb_q;
    logic signed [N-1:0]  w_a_i, w_a_q, w_b_i, w_b_q;
    logic                 r_valid, r_ovf, r_ufl;
    logic signed [N-1:0]  r_a_i, r_a_q, r_b_i, r_b_q;

    // Pop looks at pre-push occupancy, so a same-cycle push never feeds an empty-FIFO pop.
    assign w_pop  = i_en & i_tw_valid & ~w_empty;
    assign w_push = i_en & i_x0_valid & (~w_full | w_pop);
    assign w_drop = i_en & i_x0_valid & w_full & ~w_pop;

    fft_align_fifo #(.W(2*N), .L(FIFO_DEPTH_LOG2)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({i_x0_i, i_x0_q}),
        .o_data  (w_rd),
        .o_level (o_fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_x0_i, w_x0_q} = w_rd;
    assign w_w_i  = INV ? i_tw_plus_i : i_tw_minus_i;
    assign w_w_q  = INV ? i_tw_plus_q : i_tw_minus_q;
    assign w_sa_i = {w_x0_i[N-1], w_x0_i} + {w_w_i[N-1], w_w_i};
    assign w_sa_q = {w_x0_q[N-1], w_x0_q} + {w_w_q[N-1], w_w_q};
    assign w_sb_i = {w_x0_i[N-1], w_x0_i} - {w_w_i[N-1], w_w_i};
    assign w_sb_q = {w_x0_q[N-1], w_x0_q} - {w_w_q[N-1], w_w_q};
    assign w_a_i  = HALF ? w_sa_i[N:1] : sat_add(w_sa_i);
    assign w_a_q  = HALF ? w_sa_q[N:1] : sat_add(w_sa_q);
    assign w_b_i  = HALF ? w_sb_i[N:1] : sat_add(w_sb_i);
    assign w_b_q  = HALF ? w_sb_q[N:1] : sat_add(w_sb_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_a_i   <= '0;
            r_a_q   <= '0;
            r_b_i   <= '0;
            r_b_q   <= '0;
            r_ovf   <= 1'b0;
            r_ufl   <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_a_i <= w_a_i;
                r_a_q <= w_a_q;
                r_b_i <= w_b_i;
                r_b_q <= w_b_q;
            end
            if (w_drop) r_ovf <= 1'b1;
            if (i_en & i_tw_valid & w_empty) r_ufl <= 1'b1;
        end
    end

    assign o_out_valid     = r_valid;
    assign o_out_a_i       = r_a_i;
    assign o_out_a_q       = r_a_q;
    assign o_out_b_i       = r_b_i;
    assign o_out_b_q       = r_b_q;
    assign o_err_overflow  = r_ovf;
    assign o_err_underflow = r_ufl;
endmodule

// File: tb/tb_fft_butterfly_combine.sv
// tb_fft_butterfly_combine: forvard/half and inverse/none instances checked against a queue-based model.
module tb_fft_butterfly_combine;
    logic clk = 1'b0;
    logic rst_n, en, xv, tv;
    logic signed [15:0] x0_i, x0_q, mi, mq, pi, pq;

    logic h_valid, h_ovf, h_ufl, n_valid, n_ovf, n_ufl;
    logic signed [15:0] h_a_i, h_a_q, h_b_i, h_b_q, n_a_i, n_a_q, n_b_i, n_b_q;
    logic [3:0] h_lvl, n_lvl;

    int n_tests = 0;
    int n_fail = 0;

    int qi[$];
    int qq[$];
    logic e_valid, e_ovf, e_ufl;
    logic signed [15:0] e_ha_i, e_ha_q, e_hb_i, e_hb_q, e_na_i, e_na_q, e_nb_i, e_nb_q;

    logic [6:0]  h_ctl, n_ctl, e_ctl;
    logic [63:0] h_dat, n_dat, e_h, e_n;

    assign h_ctl = {h_valid, h_lvl, h_ovf, h_ufl};
    assign n_ctl = {n_valid, n_lvl, n_ovf, n_ufl};
    assign h_dat = {h_a_i, h_a_q, h_b_i, h_b_q};
    assign n_dat = {n_a_i, n_a_q, n_b_i, n_b_q};
    assign e_ctl = {e_valid, 4'(qi.size()), e_ovf, e_ufl};
    assign e_h   = {e_ha_i, e_ha_q, e_hb_i, e_hb_q};
    assign e_n   = {e_na_i, e_na_q, e_nb_i, e_nb_q};

    always #5 clk = ~clk;

    fft_butterfly_combine #(.TYPE("forvard"), .SCALE("half")) u_half (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_x0_valid(xv), .i_x0_i(x0_i), .i_x0_q(x0_q),
        .i_tw_valid(tv), .i_tw_minus_i(mi), .i_tw_minus_q(mq), .i_tw_plus_i(pi), .i_tw_plus_q(pq),
        .o_out_valid(h_valid), .o_out_a_i(h_a_i), .o_out_a_q(h_a_q), .o_out_b_i(h_b_i),
        .o_out_b_q(h_b_q), .o_fifo_level(h_lvl), .o_err_overflow(h_ovf), .o_err_underflow(h_ufl)
    );

    fft_butterfly_combine #(.TYPE("inverse"), .SCALE("none")) u_none (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_x0_valid(xv), .i_x0_i(x0_i), .i_x0_q(x0_q),
        .i_tw_valid(tv), .i_tw_minus_i(mi), .i_tw_minus_q(mq), .i_tw_plus_i(pi), .i_tw_plus_q(pq),
        .o_out_valid(n_valid), .o_out_a_i(n_a_i), .o_out_a_q(n_a_q), .o_out_b_i(n_b_i),
        .o_out_b_q(n_b_q), .o_fifo_level(n_lvl), .o_err_overflow(n_ovf), .o_err_underflow(n_ufl)
    );

    function automatic int clamp(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    task automatic model_step();
        bit pop;
        int xi, xq;
        if (!rst_n) begin
            qi.delete();
            qq.delete();
            {e_valid, e_ovf, e_ufl} = '0;
            {e_ha_i, e_ha_q, e_hb_i, e_hb_q, e_na_i, e_na_q, e_nb_i, e_nb_q} = '0;
        end else begin
            pop = en && tv && qi.size() > 0;
            if (en && tv && qi.size() == 0) e_ufl = 1'b1;
            if (pop) begin
                xi = qi.pop_front();
                xq = qq.pop_front();
                e_ha_i = 16'((xi + int'(mi)) >>> 1);
                e_ha_q = 16'((xq + int'(mq)) >>> 1);
                e_hb_i = 16'((xi - int'(mi)) >>> 1);
                e_hb_q = 16'((xq - int'(mq)) >>> 1);
                e_na_i = 16'(clamp(xi + int'(pi)));
                e_na_q = 16'(clamp(xq + int'(pq)));
                e_nb_i = 16'(clamp(xi - int'(pi)));
                e_nb_q = 16'(clamp(xq - int'(pq)));
            end
            if (en && xv) begin
                if (qi.size() < 8) begin
                    qi.push_back(int'(x0_i));
                    qq.push_back(int'(x0_q));
                end else e_ovf = 1'b1;
            end
            e_valid = pop;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic r, input logic e, input logic x, input logic t);
        rst_n = r; en = e; xv = x; tv = t;
        x0_i = 16'($urandom); x0_q = 16'($urandom);
        mi = 16'($urandom); mq = 16'($urandom);
        pi = 16'($urandom); pq = 16'($urandom);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b1);
            cyc();
            n_tests++;
            if ({h_ctl, h_dat} !== 71'd0) begin
                n_fail++;
                $display("FAIL reset_half got %h want 0", {h_ctl, h_dat});
            end
            n_tests++;
            if ({n_ctl, n_dat} !== 71'd0) begin
                n_fail++;
                $display("FAIL reset_none got %h want 0", {n_ctl, n_dat});
            end
        end
    endtask

    task automatic test_basic();
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        x0_i = 16'sd749; x0_q = 16'sd749;
        cyc();
        xv = 1'b0;
        repeat (3) cyc();
        tv = 1'b1; mi = 16'sd0; mq = -16'sd1059; pi = 16'sd100; pq = 16'sd200;
        cyc();
        n_tests++;
        if ({h_valid, h_a_i, h_a_q, h_b_i, h_b_q} !== {1'b1, 16'sd374, -16'sd155, 16'sd374, 16'sd904}) begin
            n_fail++;
            $display("FAIL basic_half got v=%0d A=(%0d,%0d) B=(%0d,%0d) want v=1 A=(374,-155) B=(374,904)",
                     h_valid, h_a_i, h_a_q, h_b_i, h_b_q);
        end
        n_tests++;
        if ({n_valid, n_a_i, n_a_q, n_b_i, n_b_q} !== {1'b1, 16'sd849, 16'sd949, 16'sd649, 16'sd549}) begin
            n_fail++;
            $display("FAIL basic_inverse got v=%0d A=(%0d,%0d) B=(%0d,%0d) want v=1 A=(849,949) B=(649,549)",
                     n_valid, n_a_i, n_a_q, n_b_i, n_b_q);
        end
        tv = 1'b0;
        cyc();
        n_tests++;
        if ({h_valid, h_dat} !== {1'b0, e_h}) begin
            n_fail++;
            $display("FAIL basic_hold got %h want %h", {h_valid, h_dat}, {1'b0, e_h});
        end
    endtask

    task automatic test_saturation();
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        x0_i = 16'sd30000;
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        pi = 16'sd10000;
        cyc();
        n_tests++;
        if ({n_a_i, n_b_i} !== {16'sd32767, 16'sd20000}) begin
            n_fail++;
            $display("FAIL sat_pos got A_i=%0d B_i=%0d want 32767 20000", n_a_i, n_b_i);
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        x0_i = -16'sd30000;
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        pi = 16'sd10000;
        cyc();
        n_tests++;
        if ({n_a_i, n_b_i} !== {-16'sd20000, -16'sd32768}) begin
            n_fail++;
            $display("FAIL sat_neg got A_i=%0d B_i=%0d want -20000 -32768", n_a_i, n_b_i);
        end
        n_tests++;
        if ({h_dat, n_dat} !== {e_h, e_n}) begin
            n_fail++;
            $display("FAIL sat_model got %h want %h", {h_dat, n_dat}, {e_h, e_n});
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 9; k++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0);
            cyc();
        end
        n_tests++;
        if ({h_lvl, h_ovf, n_lvl, n_ovf} !== {4'd8, 1'b1, 4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow got lvl=%0d ovf=%0d want lvl=8 ovf=1", h_lvl, h_ovf);
        end
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1);
            cyc();
            n_tests++;
            if ({h_ctl, h_dat, n_ctl, n_dat} !== {e_ctl, e_h, e_ctl, e_n} || !h_valid) begin
                n_fail++;
                $display("FAIL drain_%0d got %h %h %h %h want %h %h %h", k, h_ctl, h_dat, n_ctl, n_dat,
                         e_ctl, e_h, e_n);
            end
        end
    endtask

    task automatic test_underflow();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        cyc();
        n_tests++;
        if ({h_valid, h_lvl, h_ufl, n_valid, n_lvl, n_ufl} !== {1'b0, 4'd1, 1'b1, 1'b0, 4'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow got v=%0d lvl=%0d ufl=%0d want v=0 lvl=1 ufl=1", h_valid, h_lvl, h_ufl);
        end
        for (int k = 0; k < 7; k++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0);
            cyc();
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        cyc();
        n_tests++;
        if ({h_valid, h_lvl, h_ovf, n_lvl, n_ovf} !== {1'b1, 4'd8, 1'b0, 4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pushpop got v=%0d lvl=%0d ovf=%0d want v=1 lvl=8 ovf=0", h_valid, h_lvl, h_ovf);
        end
        n_tests++;
        if ({h_dat, n_dat} !== {e_h, e_n}) begin
            n_fail++;
            $display("FAIL full_pushpop_data got %h want %h", {h_dat, n_dat}, {e_h, e_n});
        end
    endtask

    task automatic test_enable_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 1'b1, k == 2);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b1);
            cyc();
            n_tests++;
            if ({h_ctl, h_dat, n_ctl, n_dat} !== {e_ctl, e_h, e_ctl, e_n} || h_lvl !== 4'd2 || h_valid) begin
                n_fail++;
                $display("FAIL enable_off_%0d got %h %h want %h %h lvl=2", k, h_ctl, h_dat, e_ctl, e_h);
            end
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0);
            cyc();
        end
        n_tests++;
        if ({h_lvl, n_lvl} !== {4'd5, 4'd5}) begin
            n_fail++;
            $display("FAIL queued5 got %0d %0d want 5", h_lvl, n_lvl);
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        n_tests++;
        if ({h_ctl, n_ctl} !== 14'd0) begin
            n_fail++;
            $display("FAIL midreset got %h %h want 0", h_ctl, n_ctl);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            set_in($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0,
                   k < 300 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) != 0);
            cyc();
            n_tests++;
            if ({h_ctl, n_ctl} !== {e_ctl, e_ctl}) begin
                n_fail++;
                $display("FAIL rand_ctl_%0d got %h %h want %h", k, h_ctl, n_ctl, e_ctl);
            end
            n_tests++;
            if ({h_dat, n_dat} !== {e_h, e_n}) begin
                n_fail++;
                $display("FAIL rand_data_%0d got %h %h want %h %h", k, h_dat, n_dat, e_h, e_n);
            end
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_underflow();
        test_enable_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
